// File: rtl/jtopll_chreg_gen.sv
// rtl/jtopll_chreg_gen.sv - OPLL channel/control register file with slot sequencer (optional readback: JTOPLL_RDBACK_EN)
module jtopll_chreg_gen #(
  parameter int NCH = 9,
  parameter int CHW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           wr,
  input  logic           a0,
  input  logic [7:0]     din,
  output logic           busy,
  output logic           drop,
  output logic [7:0]     dout,
  output logic           zero,
  output logic [CHW-1:0] ch,
  output logic           op,
  output logic [8:0]     fnum,
  output logic [2:0]     block,
  output logic           keyon,
  output logic           sus_en,
  output logic [3:0]     inst,
  output logic [3:0]     vol,
  output logic [63:0]    upatch,
  output logic           rhy_en,
  output logic [4:0]     rhy_kon
);
  localparam int NREG = 1 << CHW;
  localparam logic [CHW-1:0] LAST = CHW'(NCH - 1);

  logic [7:0]     addr;
  logic [8:0]     fnum_m  [NREG];
  logic [2:0]     block_m [NREG];
  logic           keyon_m [NREG];
  logic           sus_m   [NREG];
  logic [3:0]     inst_m  [NREG];
  logic [3:0]     vol_m   [NREG];

  logic [1:0]     pend_kind;
  logic [CHW-1:0] pend_ch;
  logic [7:0]     pend_din;

  logic           chan_hit;
  logic [CHW-1:0] wch;
  logic [CHW-1:0] ch_nxt;
  logic           apply;

  // Address decode for channel registers and next-slot channel index
  always_comb begin
    chan_hit = (addr[7:6] == 2'b00) && (addr[5:4] != 2'b00) &&
               ({1'b0, addr[3:0]} < 5'(NCH));
    wch      = CHW'(addr[3:0]);
    ch_nxt   = ch;
    if (op) ch_nxt = (ch == LAST) ? '0 : ch + CHW'(1);
    apply    = cen && busy && op && (ch == pend_ch);
  end

  assign zero = (ch == '0) && !op;

  // Slot sequencer: op toggles every cen, channel advances after the carrier slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= 1'b0;
      ch <= '0;
    end else if (cen) begin
      op <= ~op;
      ch <= ch_nxt;
    end
  end

  // CPU interface: address latch, pending slot, busy/drop handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= 8'h00;
      busy      <= 1'b0;
      drop      <= 1'b0;
      pend_kind <= 2'd0;
      pend_ch   <= '0;
      pend_din  <= 8'h00;
    end else begin
      drop <= 1'b0;
      if (wr && !a0) addr <= din;
      if (apply) busy <= 1'b0;
      // acceptance looks at busy before this edge, so a write racing the apply is dropped
      if (wr && a0 && chan_hit) begin
        if (busy) begin
          drop <= 1'b1;
        end else begin
          busy      <= 1'b1;
          pend_kind <= addr[5:4];
          pend_ch   <= wch;
          pend_din  <= din;
        end
      end
    end
  end

  // Immediate registers: user patch bytes and rhythm control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upatch  <= 64'd0;
      rhy_en  <= 1'b0;
      rhy_kon <= 5'd0;
    end else if (wr && a0) begin
      if (addr[7:3] == 5'd0) upatch[{addr[2:0], 3'b000} +: 8] <= din;
      if (addr == 8'h0E) begin
        rhy_en  <= din[5];
        rhy_kon <= din[4:0];
      end
    end
  end

  // Channel register file, updated only at the end of the target channel's carrier slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        fnum_m[i]  <= 9'd0;
        block_m[i] <= 3'd0;
        keyon_m[i] <= 1'b0;
        sus_m[i]   <= 1'b0;
        inst_m[i]  <= 4'd0;
        vol_m[i]   <= 4'd0;
      end
    end else if (apply) begin
      case (pend_kind)
        2'd1: fnum_m[pend_ch][7:0] <= pend_din;
        2'd2: begin
          fnum_m[pend_ch][8] <= pend_din[0];
          block_m[pend_ch]   <= pend_din[3:1];
          keyon_m[pend_ch]   <= pend_din[4];
          sus_m[pend_ch]     <= pend_din[5];
        end
        2'd3: begin
          inst_m[pend_ch] <= pend_din[7:4];
          vol_m[pend_ch]  <= pend_din[3:0];
        end
        default: ;
      endcase
    end
  end

  // Channel outputs follow the channel that becomes current on each cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fnum   <= 9'd0;
      block  <= 3'd0;
      keyon  <= 1'b0;
      sus_en <= 1'b0;
      inst   <= 4'd0;
      vol    <= 4'd0;
    end else if (cen) begin
      fnum   <= fnum_m[ch_nxt];
      block  <= block_m[ch_nxt];
      keyon  <= keyon_m[ch_nxt];
      sus_en <= sus_m[ch_nxt];
      inst   <= inst_m[ch_nxt];
      vol    <= vol_m[ch_nxt];
    end
  end

`ifdef JTOPLL_RDBACK_EN
  logic [7:0] rd_val;

  // Readback mux; a pending channel write is not visible until applied
  always_comb begin
    rd_val = 8'hFF;
    if (addr[7:3] == 5'd0) begin
      rd_val = upatch[{addr[2:0], 3'b000} +: 8];
    end else if (addr == 8'h0E) begin
      rd_val = {2'b00, rhy_en, rhy_kon};
    end else if (chan_hit) begin
      case (addr[5:4])
        2'd1:    rd_val = fnum_m[wch][7:0];
        2'd2:    rd_val = {2'b00, sus_m[wch], keyon_m[wch], block_m[wch], fnum_m[wch][8]};
        default: rd_val = {inst_m[wch], vol_m[wch]};
      endcase
    end
  end

  // Registered readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= 8'h00;
    else        dout <= rd_val;
  end
`else
  assign dout = 8'h00;
`endif

endmodule

// File: doc/jtopll_chreg_gen.md
# jtopll_chreg_gen

Parametrised OPLL channel/control register file that succeeds the fixed 9-channel register block. It takes CPU address/data writes at any time and holds channel writes pending until the channel's slot pair has finished, so both operators of a channel always see the same configuration. It runs its own slot sequencer for `NCH` channels (2 slots each) and presents the current channel's registered configuration to the PG/EG/OP stages.

## Interface
Parameters:
- `NCH`, 9: channel count, 1..16; channel registers occupy 0x10+ch, 0x20+ch, 0x30+ch
- `CHW`, 4: channel index width, must satisfy 2^CHW ≥ NCH

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: reset, asynchronous, active-low
- `cen` in 1: clock enable; sequencer and register application advance only when high
- `wr` in 1: CPU write strobe, one `clk` per access
- `a0` in 1: 0 = address write, 1 = data write
- `din` in 8: CPU data
- `busy` out 1: channel write pending
- `drop` out 1: one-`clk` pulse when a data write is discarded
- `dout` out 8: readback of register at latched address (see Configuration)
- `zero` out 1: high during slot ch0/op0
- `ch` out CHW: current channel index
- `op` out 1: 0 = modulator slot, 1 = carrier slot
- `fnum` out 9, `block` out 3, `keyon` out 1, `sus_en` out 1, `inst` out 4, `vol` out 4: current channel config, registered
- `upatch` out 64: user patch, byte n = register 0x0n
- `rhy_en` out 1, `rhy_kon` out 5: register 0x0E bits 5 and 4:0

## Operation
- Address write (`wr & !a0`): `addr` ← `din`. Accepted even while `busy`.
- Data write (`wr & a0`), decoded on `addr`:
  - 0x00–0x07: `upatch` byte written on the next `clk` edge; applied immediately; no `busy`.
  - 0x0E: rhythm register written on the next edge; applied immediately.
  - 0x10+ch, 0x20+ch, 0x30+ch with ch < NCH: `busy` = 0 → latch {kind, ch, din} into the pending slot and set `busy`. `busy` = 1 → discard and pulse `drop`.
  - Any other address, including ch ≥ NCH: ignored; no `busy`, no `drop`.
- Register fields:
  - 0x10+ch: fnum[7:0].
  - 0x20+ch: {sus_en, keyon, block, fnum[8]} = din[5:0].
  - 0x30+ch: {inst, vol} = din.
- Sequencer: on each `cen` edge `op` toggles. When `op` goes 1→0, `ch` increments and wraps from NCH-1 to 0. `zero` = (ch==0 && op==0).
- Pending application:
  - Applied on the `cen` edge where `ch`==pending ch and `op`==1, i.e. the end of that channel's carrier slot.
  - `busy` clears on the same edge.
- Output registers:
  - On each `cen` edge, channel outputs load from the register file entry for the channel index that becomes current.
  - Because a pending write applies only on the `op`=1→0 edge of its own channel, that channel is not reloaded until its next visit.
- Rhythm: channels 6–8 are not altered by this block; `rhy_*` are plain outputs.

## Timing
- Reset (`rst_n` low): all registers, `upatch`, `addr`, `ch`, `op` and channel outputs = 0; `busy` = 0; `drop` = 0; `zero` = 1; `dout` = 0.
- Immediate registers: value visible on outputs one `clk` after the write.
- Channel writes:
  - Latency is one to 2·NCH `cen` pulses, plus one `cen` before the new value appears on that channel's outputs.
  - Worst case is a write accepted just after its channel's apply edge.
- `cen` held low: the sequencer freezes and `busy` holds indefinitely. Immediate writes and readback still operate.
- Simultaneous data write and apply edge (pending slot freed in the same `clk`): the new write is discarded with `drop`. Acceptance uses `busy` before the edge.
- Reset during a pending write: the pending write is lost and `busy` = 0.
- `wr` with `a0`=1 before any address write: targets 0x00.

## Configuration
- `JTOPLL_RDBACK_EN` defined:
  - `dout` is registered one `clk` after `addr` or the addressed register changes.
  - `dout` returns the stored value for 0x00–0x07, 0x0E and valid channel addresses.
  - Reserved bits read 0; unmapped addresses read 0xFF.
  - A pending (unapplied) channel write reads back the old value.
- Not defined: `dout` tied to 0; no readback mux is synthesised.

## Test plan
- Reset mid-sequence with `cen` toggling -> `ch`=0, `op`=0, `zero`=1, `busy`=0, all config outputs 0.
- Write addr 0x13, data 0x5A while ch=1, `cen` every clk -> `busy` stays 1 until the ch=3/op=1 `cen` edge; fnum[7:0]=0x5A appears at the next ch=3 visit; ch=3 outputs never change between op0 and op1.
- Write 0x23/0x15, then 0x33/0x7F while busy -> second write `drop` pulses one clk; after apply ch3 has keyon=1, block=2, fnum[8]=1 and inst/vol unchanged.
- NCH=16: write 0x1F/0x01 -> accepted and applied at ch=15. NCH=9: write 0x19 -> ignored, `busy`=0, `drop`=0.
- Write 0x03/0xA5, then 0x0E/0x3F -> `upatch`[31:24]=0xA5 and `rhy_en`=1, `rhy_kon`=0x1F one clk later, without `busy`.
- With `JTOPLL_RDBACK_EN`: addr 0x13 after apply -> `dout`=0x5A; addr 0x40 -> 0xFF; pending 0x30 write reads old value until applied.
